// File: rtl/operand_issue_stage_pkg.sv
// Opcode map, instruction field positions and per-opcode decode helper for the operand issue stage.
// Shared by operand_issue_stage (ISSUE_BYPASS_EN selects same-cycle writeback forwarding there).
package operand_issue_stage_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int INSTR_W        = 16;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SHL   = 4'b0101;
  localparam logic [3:0] OP_SHR   = 4'b0110;
  localparam logic [3:0] OP_BEQ   = 4'b0111;
  localparam logic [3:0] OP_NOP   = 4'b1000;
  localparam logic [3:0] OP_LOAD  = 4'b1001;
  localparam logic [3:0] OP_STORE = 4'b1010;

  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RS1_LSB = 8;
  localparam int RS2_LSB = 0;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 8;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic uses_rd;
    logic writes_rd;
    logic alu_legal;
    logic is_illegal;
    logic use_imm;
    logic is_store;
  } decode_t;

  function automatic decode_t decode_op(input logic [3:0] op);
    decode_t d;
    d = '0;
    if (op <= OP_SHR) begin
      d.uses_rs1  = 1'b1;
      d.uses_rs2  = 1'b1;
      d.uses_rd   = 1'b1;
      d.writes_rd = 1'b1;
      d.alu_legal = 1'b1;
    end else begin
      case (op)
        OP_BEQ: begin
          d.uses_rs1  = 1'b1;
          d.uses_rs2  = 1'b1;
          d.alu_legal = 1'b1;
        end
        OP_NOP: ;
        OP_LOAD: begin
          d.uses_rs1  = 1'b1;
          d.uses_rd   = 1'b1;
          d.writes_rd = 1'b1;
          d.alu_legal = 1'b1;
          d.use_imm   = 1'b1;
        end
        OP_STORE: begin
          d.uses_rs1  = 1'b1;
          d.uses_rd   = 1'b1;
          d.alu_legal = 1'b1;
          d.use_imm   = 1'b1;
          d.is_store  = 1'b1;
        end
        default: d.is_illegal = 1'b1;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/operand_issue_stage_regfile.sv
// Small register file: three asynchronous read ports, one synchronous write port, synchronous clear.
module issue_regfile
  import operand_issue_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  input  logic [REG_AW-1:0] raddr3,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] rdata3
);

  localparam int DEPTH = 1 << REG_AW;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]  wsel;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wsel
      assign wsel[gi] = we && (waddr == REG_AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        mem_reg[i] <= '0;
      end else if (wsel[i]) begin
        mem_reg[i] <= wdata;
      end
    end
  end

  assign rdata1 = mem_reg[raddr1];
  assign rdata2 = mem_reg[raddr2];
  assign rdata3 = mem_reg[raddr3];

endmodule

// File: rtl/operand_issue_stage.sv
// Decode / operand-fetch stage with scoreboard hazard stalls and a single registered issue slot.
// Optional feature macro: ISSUE_BYPASS_EN (same-cycle writeback forwarded into hazard check and operands).
module operand_issue_stage
  import operand_issue_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int REG_AW = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [15:0]        in_instr,
  output logic               in_ready,
  output logic               iss_valid,
  input  logic               iss_ready,
  output logic [3:0]         opcode,
  output logic [DATA_W-1:0]  data_in1,
  output logic [DATA_W-1:0]  data_in2,
  output logic               ALU_src,
  output logic [DATA_W-1:0]  store_data,
  output logic [REG_AW-1:0]  iss_rd,
  output logic               iss_wr,
  output logic               illegal,
  input  logic               wb_en,
  input  logic [REG_AW-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data
);

  localparam int DEPTH = 1 << REG_AW;

  logic [3:0]        f_op;
  logic [REG_AW-1:0] f_rd;
  logic [REG_AW-1:0] f_rs1;
  logic [REG_AW-1:0] f_rs2;
  logic [IMM_W-1:0]  f_imm;
  decode_t           dec;

  assign f_op  = in_instr[OP_LSB +: 4];
  assign f_rd  = in_instr[RD_LSB +: REG_AW];
  assign f_rs1 = in_instr[RS1_LSB +: REG_AW];
  assign f_rs2 = in_instr[RS2_LSB +: REG_AW];
  assign f_imm = in_instr[IMM_LSB +: IMM_W];
  assign dec   = decode_op(f_op);

  logic [DATA_W-1:0] rf_rs1;
  logic [DATA_W-1:0] rf_rs2;
  logic [DATA_W-1:0] rf_rd;

  issue_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (f_rs1),
    .raddr2 (f_rs2),
    .raddr3 (f_rd),
    .rdata1 (rf_rs1),
    .rdata2 (rf_rs2),
    .rdata3 (rf_rd)
  );

  logic [DEPTH-1:0] sb_reg;
  logic [DEPTH-1:0] sb_next;
  logic [DEPTH-1:0] wb_mask;
  logic [DEPTH-1:0] sb_view;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wb_mask
      assign wb_mask[gi] = wb_en && (wb_addr == REG_AW'(gi));
    end
  endgenerate

  logic [DATA_W-1:0] op_rs1;
  logic [DATA_W-1:0] op_rs2;
  logic [DATA_W-1:0] op_rd;

`ifdef ISSUE_BYPASS_EN
  // A writeback landing this cycle both releases its pending bit and supplies the operand.
  assign sb_view = sb_reg & ~wb_mask;
  assign op_rs1  = (wb_en && wb_addr == f_rs1) ? wb_data : rf_rs1;
  assign op_rs2  = (wb_en && wb_addr == f_rs2) ? wb_data : rf_rs2;
  assign op_rd   = (wb_en && wb_addr == f_rd)  ? wb_data : rf_rd;
`else
  assign sb_view = sb_reg;
  assign op_rs1  = rf_rs1;
  assign op_rs2  = rf_rs2;
  assign op_rd   = rf_rd;
`endif

  logic hazard;
  logic accept;

  assign hazard = (dec.uses_rs1 && sb_view[f_rs1]) ||
                  (dec.uses_rs2 && sb_view[f_rs2]) ||
                  (dec.uses_rd  && sb_view[f_rd]);

  logic              valid_reg;
  logic [3:0]        op_reg;
  logic [DATA_W-1:0] d1_reg;
  logic [DATA_W-1:0] d2_reg;
  logic              src_reg;
  logic [DATA_W-1:0] sd_reg;
  logic [REG_AW-1:0] rd_reg;
  logic              wr_reg;
  logic              ill_reg;

  assign in_ready = !hazard && (!valid_reg || iss_ready);
  assign accept   = in_valid && in_ready;

  // Clear first so a same-cycle set on the same register wins.
  always_comb begin
    sb_next = sb_reg & ~wb_mask;
    if (accept && dec.writes_rd) begin
      sb_next[f_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_reg    <= '0;
      valid_reg <= 1'b0;
      op_reg    <= '0;
      d1_reg    <= '0;
      d2_reg    <= '0;
      src_reg   <= 1'b0;
      sd_reg    <= '0;
      rd_reg    <= '0;
      wr_reg    <= 1'b0;
      ill_reg   <= 1'b0;
    end else begin
      sb_reg  <= sb_next;
      ill_reg <= accept && dec.is_illegal;
      if (accept) begin
        valid_reg <= 1'b1;
        op_reg    <= f_op;
        d1_reg    <= op_rs1;
        d2_reg    <= dec.use_imm ? DATA_W'(f_imm) : op_rs2;
        src_reg   <= dec.alu_legal;
        sd_reg    <= dec.is_store ? op_rd : '0;
        rd_reg    <= f_rd;
        wr_reg    <= dec.writes_rd;
      end else if (iss_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign iss_valid  = valid_reg;
  assign opcode     = op_reg;
  assign data_in1   = d1_reg;
  assign data_in2   = d2_reg;
  assign ALU_src    = src_reg;
  assign store_data = sd_reg;
  assign iss_rd     = rd_reg;
  assign iss_wr     = wr_reg;
  assign illegal    = ill_reg;

endmodule

// File: tb/tb_operand_issue_stage.sv
// Randomised and directed bench for operand_issue_stage against a behavioural issue-slot model.
module tb_operand_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic        iss_valid;
  logic        iss_ready;
  logic [3:0]  opcode;
  logic [7:0]  data_in1;
  logic [7:0]  data_in2;
  logic        ALU_src;
  logic [7:0]  store_data;
  logic [1:0]  iss_rd;
  logic        iss_wr;
  logic        illegal;
  logic        wb_en;
  logic [1:0]  wb_addr;
  logic [7:0]  wb_data;

  always #5 clk = ~clk;

  operand_issue_stage #(.DATA_W(8), .REG_AW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .iss_valid  (iss_valid),
    .iss_ready  (iss_ready),
    .opcode     (opcode),
    .data_in1   (data_in1),
    .data_in2   (data_in2),
    .ALU_src    (ALU_src),
    .store_data (store_data),
    .iss_rd     (iss_rd),
    .iss_wr     (iss_wr),
    .illegal    (illegal),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: architectural registers, pending-write flags and the issue slot contents.
  logic [7:0] m_reg  [4];
  bit         m_pend [4];
  bit         m_valid, m_src, m_wr, m_ill;
  logic [3:0] m_op;
  logic [7:0] m_d1, m_d2, m_sd;
  logic [1:0] m_rd;

  function automatic bit f_writes(input int op);  return (op <= 6) || (op == 9);      endfunction
  function automatic bit f_rs1(input int op);     return (op <= 10) && (op != 8);     endfunction
  function automatic bit f_rs2(input int op);     return op <= 7;                     endfunction
  function automatic bit f_rdu(input int op);     return (op == 10) || f_writes(op);  endfunction
  function automatic bit f_illegal(input int op); return op > 10;                     endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_reg[i]  = 8'h00;
      m_pend[i] = 1'b0;
    end
    m_valid = 0; m_src = 0; m_wr = 0; m_ill = 0;
    m_op = 0; m_d1 = 0; m_d2 = 0; m_sd = 0; m_rd = 0;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check in_ready, advance the model.
  task automatic step(input bit r, input bit iv, input logic [15:0] ins, input bit ir,
                      input bit we, input logic [1:0] wa, input logic [7:0] wd);
    int op;
    logic [1:0] rd, rs1, rs2;
    bit pview [4];
    bit hz, exp_ready, acc;
    logic [7:0] v1, v2, v3;
    @(negedge clk);
    chk("iss_valid",  iss_valid,  m_valid);
    chk("opcode",     opcode,     m_op);
    chk("data_in1",   data_in1,   m_d1);
    chk("data_in2",   data_in2,   m_d2);
    chk("ALU_src",    ALU_src,    m_src);
    chk("store_data", store_data, m_sd);
    chk("iss_rd",     iss_rd,     m_rd);
    chk("iss_wr",     iss_wr,     m_wr);
    chk("illegal",    illegal,    m_ill);
    rst = r; in_valid = iv; in_instr = ins; iss_ready = ir;
    wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    op  = int'(ins[15:12]);
    rd  = ins[11:10];
    rs1 = ins[9:8];
    rs2 = ins[1:0];
    for (int i = 0; i < 4; i++) pview[i] = m_pend[i];
`ifdef ISSUE_BYPASS_EN
    if (we) pview[wa] = 1'b0;
`endif
    hz = (f_rs1(op) && pview[rs1]) || (f_rs2(op) && pview[rs2]) || (f_rdu(op) && pview[rd]);
    exp_ready = !hz && (!m_valid || ir);
    chk("in_ready", in_ready, exp_ready);
    acc = iv && exp_ready;
    v1 = m_reg[rs1]; v2 = m_reg[rs2]; v3 = m_reg[rd];
`ifdef ISSUE_BYPASS_EN
    if (we && wa == rs1) v1 = wd;
    if (we && wa == rs2) v2 = wd;
    if (we && wa == rd)  v3 = wd;
`endif
    if (r) begin
      model_reset();
    end else begin
      m_ill = acc && f_illegal(op);
      if (acc) begin
        m_valid = 1;
        m_op    = ins[15:12];
        m_d1    = v1;
        m_d2    = (op == 9 || op == 10) ? ins[7:0] : v2;
        m_src   = (op <= 10) && (op != 8);
        m_sd    = (op == 10) ? v3 : 8'h00;
        m_rd    = rd;
        m_wr    = f_writes(op);
      end else if (ir) begin
        m_valid = 0;
      end
      if (we) begin
        m_reg[wa]  = wd;
        m_pend[wa] = 1'b0;
      end
      if (acc && f_writes(op)) m_pend[rd] = 1'b1;
    end
  endtask

  task automatic idle(input bit we, input logic [1:0] wa, input logic [7:0] wd);
    step(0, 0, 16'h0000, 1, we, wa, wd);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_instr = 0; iss_ready = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    model_reset();
    step(1, 0, 16'h0000, 0, 1, 2'd1, 8'h33);
    step(1, 0, 16'h0000, 0, 0, 2'd0, 8'h00);
    after_edge();
    chk("reset_iss_valid", iss_valid, 0);
    chk("reset_illegal",   illegal,   0);

    // 1: preload r2=5, r3=7 then ADD r1=r2+r3
    idle(1, 2'd2, 8'd5);
    idle(1, 2'd3, 8'd7);
    step(0, 1, {4'h0, 2'd1, 2'd2, 8'h03}, 1, 0, 0, 0);
    after_edge();
    chk("t1_valid", iss_valid, 1);
    chk("t1_op",    opcode,    4'h0);
    chk("t1_d1",    data_in1,  8'd5);
    chk("t1_d2",    data_in2,  8'd7);
    chk("t1_src",   ALU_src,   1);
    chk("t1_rd",    iss_rd,    2'd1);
    chk("t1_wr",    iss_wr,    1);

    // 2: SUB r2=r1-r3 waits on pending r1 until writeback of 9
    step(0, 1, {4'h1, 2'd2, 2'd1, 8'h03}, 1, 0, 0, 0);
    chk("t2_stall", in_ready, 0);
    step(0, 1, {4'h1, 2'd2, 2'd1, 8'h03}, 1, 1, 2'd1, 8'd9);
`ifdef ISSUE_BYPASS_EN
    chk("t2_bypass_ready", in_ready, 1);
`else
    chk("t2_wb_cycle_stall", in_ready, 0);
    step(0, 1, {4'h1, 2'd2, 2'd1, 8'h03}, 1, 0, 0, 0);
    chk("t2_ready_after_wb", in_ready, 1);
`endif
    after_edge();
    chk("t2_op", opcode,   4'h1);
    chk("t2_d1", data_in1, 8'd9);

    // 3: slot full with iss_ready low, then drained
    step(0, 1, {4'h0, 2'd0, 2'd3, 8'h03}, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, {4'h4, 2'd1, 2'd3, 8'h03}, 0, 0, 0, 0);
      chk("t3_stall", in_ready, 0);
    end
    step(0, 1, {4'h4, 2'd1, 2'd3, 8'h03}, 1, 0, 0, 0);
    after_edge();
    chk("t3_op", opcode, 4'h4);

    // 4: STORE rd=r2 rs1=r1 imm=0x10
    idle(1, 2'd1, 8'h20);
    idle(1, 2'd2, 8'hAB);
    idle(1, 2'd0, 8'h11);
    step(0, 1, {4'hA, 2'd2, 2'd1, 8'h10}, 1, 0, 0, 0);
    after_edge();
    chk("t4_op", opcode,     4'hA);
    chk("t4_d1", data_in1,   8'h20);
    chk("t4_d2", data_in2,   8'h10);
    chk("t4_sd", store_data, 8'hAB);
    chk("t4_wr", iss_wr,     0);
    chk("t4_sb", dut.sb_reg, 4'b0000);

    // 5: illegal opcode
    step(0, 1, 16'hC000, 1, 0, 0, 0);
    after_edge();
    chk("t5_src", ALU_src, 0);
    chk("t5_wr",  iss_wr,  0);
    chk("t5_ill", illegal, 1);
    idle(0, 0, 0);
    after_edge();
    chk("t5_ill_pulse", illegal, 0);

    // 6: reset while r1 pending and slot occupied; writeback during reset is dropped
    step(0, 1, {4'h0, 2'd1, 2'd2, 8'h03}, 0, 0, 0, 0);
    step(1, 0, 16'h0000, 0, 1, 2'd3, 8'h55);
    after_edge();
    chk("t6_valid", iss_valid,  0);
    chk("t6_sb",    dut.sb_reg, 4'b0000);
    step(0, 1, {4'h0, 2'd0, 2'd3, 8'h03}, 1, 0, 0, 0);
    after_edge();
    chk("t6_r3", data_in1, 8'h00);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      logic [15:0] ins;
      bit r, iv, ir, we;
      ins = 16'($urandom);
      r   = ($urandom_range(0, 199) == 0);
      iv  = ($urandom_range(0, 9) < 7);
      ir  = ($urandom_range(0, 9) < 7);
      we  = ($urandom_range(0, 9) < 4);
      step(r, iv, ins, ir, we, 2'($urandom), 8'($urandom));
    end
    idle(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
